// File: rtl/nand_lab_pkg.sv
// Shared definitions for the NAND truth-table sweeper: reference-gate modes,
// FSM state encoding and the reference-gate evaluator.
package nand_lab_pkg;

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_NAND = 3'd2;
  localparam logic [2:0] MODE_NOR  = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;
  localparam logic [2:0] MODE_TT   = 3'd6;
  localparam logic [2:0] MODE_ZERO = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // x and tt are zero-extended to the largest supported N (4); only the low n bits of x count.
  function automatic logic ref_gate(input logic [2:0] mode, input logic [3:0] x,
                                    input int n, input logic [15:0] tt);
    logic v_and;
    logic v_or;
    logic v_xor;
    logic v_out;
    v_and = 1'b1;
    v_or  = 1'b0;
    v_xor = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        v_and = v_and & x[i];
        v_or  = v_or | x[i];
        v_xor = v_xor ^ x[i];
      end
    end
    case (mode)
      MODE_AND:  v_out = v_and;
      MODE_OR:   v_out = v_or;
      MODE_NAND: v_out = ~v_and;
      MODE_NOR:  v_out = ~v_or;
      MODE_XOR:  v_out = v_xor;
      MODE_XNOR: v_out = ~v_xor;
      MODE_TT:   v_out = tt[x];
      default:   v_out = 1'b0;
    endcase
    return v_out;
  endfunction

endpackage

// File: rtl/nand_truth_sweeper_if.sv
// Control/result bundle of the sweeper; master drives the request, slave is the sweeper.
interface nand_truth_sweeper_if #(
  parameter int N  = 2,
  parameter int MW = 3
);
  logic                start;
  logic [(1<<N)-1:0]   tt;
  logic [MW-1:0]       mode;
  logic                busy;
  logic                valid;
  logic [N-1:0]        m_idx;
  logic [N-1:0]        x;
  logic                s_nand;
  logic                s_ref;
  logic                mismatch;
  logic [N:0]          err_count;
  logic                done;
  logic                pass;

  modport master (
    output start, tt, mode,
    input  busy, valid, m_idx, x, s_nand, s_ref, mismatch, err_count, done, pass
  );

  modport slave (
    input  start, tt, mode,
    output busy, valid, m_idx, x, s_nand, s_ref, mismatch, err_count, done, pass
  );
endinterface

// File: rtl/nand_sop_eval.sv
// Sum-of-products of an N-input truth table, built from 2-input nand primitives only.
// Wide NANDs are an AND chain (nand + self-nand) closed by a final self-nand.
module nand_sop_eval #(
  parameter int N = 2
) (
  output wire              s,
  input  wire [N-1:0]      x,
  input  wire [(1<<N)-1:0] tt
);
  localparam int NT = 1 << N;

  wire [N-1:0] w_xn;

  for (genvar i = 0; i < N; i++) begin : g_inv
    nand u_inv (w_xn[i], x[i], x[i]);
  end

  for (genvar k = 0; k < NT; k++) begin : g_term
    for (genvar i = 0; i < N; i++) begin : g_lit
      wire w_prev;
      wire w_lit;
      wire w_n;
      wire w_a;
      if (i == 0) begin : g_first
        assign w_prev = tt[k];
      end else begin : g_next
        assign w_prev = g_lit[i-1].w_a;
      end
      if (((k >> i) & 1) == 1) begin : g_pos
        assign w_lit = x[i];
      end else begin : g_neg
        assign w_lit = w_xn[i];
      end
      nand u_n (w_n, w_prev, w_lit);
      nand u_a (w_a, w_n, w_n);
    end
    wire w_t;
    nand u_t (w_t, g_lit[N-1].w_a, g_lit[N-1].w_a);
  end

  // Output stage: AND of all terms, then inverted, i.e. nand(t_0..t_NT-1).
  for (genvar j = 0; j < NT; j++) begin : g_out
    wire w_prev;
    wire w_n;
    wire w_a;
    if (j == 0) begin : g_first
      assign w_prev = 1'b1;
    end else begin : g_next
      assign w_prev = g_out[j-1].w_a;
    end
    nand u_n (w_n, w_prev, g_term[j].w_t);
    nand u_a (w_a, w_n, w_n);
  end

  nand u_s (s, g_out[NT-1].w_a, g_out[NT-1].w_a);

endmodule

// File: rtl/nand_truth_sweeper.sv
// Sweeps all 2^N minterms of a latched truth table, comparing the NAND-NAND
// realisation against a selectable reference gate and counting mismatches.
module nand_truth_sweeper
  import nand_lab_pkg::*;
#(
  parameter int N  = 2,
  parameter int MW = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  nand_truth_sweeper_if.slave  bus
);
  localparam int             NT     = 1 << N;
  localparam logic [N-1:0]   M_LAST = '1;

  state_t           r_state;
  logic [N-1:0]     r_m;
  logic [NT-1:0]    r_tt;
  logic [MW-1:0]    r_mode;
  logic [N:0]       r_err;
  logic             r_busy;
  logic             r_valid;
  logic             r_done;
  logic             r_pass;

  logic             w_s_nand;
  logic             w_s_ref;
  logic             w_mismatch;
  logic [N:0]       w_err_nxt;

  nand_sop_eval #(.N(N)) u_sop (
    .s  (w_s_nand),
    .x  (r_m),
    .tt (r_tt)
  );

  assign w_s_ref    = ref_gate(r_mode, 4'(r_m), N, 16'(r_tt));
  assign w_mismatch = r_valid & (w_s_nand != w_s_ref);
  assign w_err_nxt  = w_mismatch ? r_err + 1'b1 : r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_m     <= '0;
      r_tt    <= '0;
      r_mode  <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_tt    <= bus.tt;
            r_mode  <= bus.mode;
            r_m     <= '0;
            r_err   <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_err <= w_err_nxt;
          // The last minterm's mismatch is folded into pass here, so pass is ready alongside done.
          if (r_m == M_LAST) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
            r_state <= ST_FIN;
          end else begin
            r_m <= r_m + 1'b1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.valid     = r_valid;
  assign bus.m_idx     = r_m;
  assign bus.x         = r_m;
  assign bus.s_nand    = w_s_nand;
  assign bus.s_ref     = w_s_ref;
  assign bus.mismatch  = w_mismatch;
  assign bus.err_count = r_err;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;

endmodule

// File: tb/tb_nand_truth_sweeper.sv
// Scoreboard bench for nand_truth_sweeper: an N=2 and an N=3 instance share clock and reset.
module tb_nand_truth_sweeper;
  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  nand_truth_sweeper_if #(.N(2), .MW(3)) b2 ();
  nand_truth_sweeper_if #(.N(3), .MW(3)) b3 ();

  nand_truth_sweeper #(.N(2), .MW(3)) u_dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  nand_truth_sweeper #(.N(3), .MW(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

  typedef struct { int m; bit s; bit r; } vexp_t;
  typedef struct { int err; bit pass; } dexp_t;

  vexp_t q2v[$];
  vexp_t q3v[$];
  dexp_t q2d[$];
  dexp_t q3d[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit ref_m(input logic [2:0] md, input int m, input int n, input logic [7:0] t);
    int ones = 0;
    for (int i = 0; i < n; i++) if (((m >> i) & 1) == 1) ones++;
    case (md)
      3'd0:    return ones == n;
      3'd1:    return ones != 0;
      3'd2:    return ones != n;
      3'd3:    return ones == 0;
      3'd4:    return (ones % 2) == 1;
      3'd5:    return (ones % 2) == 0;
      3'd6:    return t[m];
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input bit sel, input logic [7:0] t, input logic [2:0] md, input int lo, input int hi);
    int n = sel ? 3 : 2;
    vexp_t e;
    for (int m = lo; m <= hi; m++) begin
      e.m = m;
      e.s = t[m];
      e.r = ref_m(md, m, n, t);
      if (sel) q3v.push_back(e); else q2v.push_back(e);
    end
  endtask

  task automatic pushd(input bit sel, input int err, input bit pass);
    dexp_t d;
    d.err = err;
    d.pass = pass;
    if (sel) q3d.push_back(d); else q2d.push_back(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit get_done(input bit sel);
    return sel ? b3.done : b2.done;
  endfunction

  function automatic bit get_valid(input bit sel);
    return sel ? b3.valid : b2.valid;
  endfunction

  task automatic wait_done(input bit sel, input int exp_lat, input string nm);
    int c = 0;
    while (!get_done(sel) && c < 40) begin
      tick();
      c++;
    end
    chk({nm, "_done_lat"}, c, exp_lat);
  endtask

  task automatic sweep(input bit sel, input logic [7:0] t, input logic [2:0] md,
                       input int exp_err, input bit exp_pass, input string nm);
    int n = sel ? 3 : 2;
    push(sel, t, md, 0, (1 << n) - 1);
    pushd(sel, exp_err, exp_pass);
    if (sel) begin
      b3.start = 1'b1; b3.tt = t; b3.mode = md;
    end else begin
      b2.start = 1'b1; b2.tt = t[3:0]; b2.mode = md;
    end
    tick();
    b2.start = 1'b0;
    b3.start = 1'b0;
    chk({nm, "_first_valid"}, get_valid(sel), 1);
    wait_done(sel, 1 << n, nm);
    tick();
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a valid minterm or a done pulse.
  always @(negedge clk) begin
    vexp_t ve;
    dexp_t de;
    if (mon_en) begin
      if (b2.valid) begin
        if (q2v.size() == 0) chk("n2_unexpected_valid", 1, 0);
        else begin
          ve = q2v.pop_front();
          chk("n2_m_idx", b2.m_idx, ve.m);
          chk("n2_x", b2.x, ve.m);
          chk("n2_s_nand", b2.s_nand, ve.s);
          chk("n2_s_ref", b2.s_ref, ve.r);
          chk("n2_mismatch", b2.mismatch, ve.s != ve.r);
          chk("n2_busy_run", b2.busy, 1);
        end
      end
      if (b2.done) begin
        if (q2d.size() == 0) chk("n2_unexpected_done", 1, 0);
        else begin
          de = q2d.pop_front();
          chk("n2_err_count", b2.err_count, de.err);
          chk("n2_pass", b2.pass, de.pass);
          chk("n2_busy_fin", b2.busy, 0);
          chk("n2_valid_fin", b2.valid, 0);
        end
      end
      if (b3.valid) begin
        if (q3v.size() == 0) chk("n3_unexpected_valid", 1, 0);
        else begin
          ve = q3v.pop_front();
          chk("n3_m_idx", b3.m_idx, ve.m);
          chk("n3_x", b3.x, ve.m);
          chk("n3_s_nand", b3.s_nand, ve.s);
          chk("n3_s_ref", b3.s_ref, ve.r);
          chk("n3_mismatch", b3.mismatch, ve.s != ve.r);
          chk("n3_busy_run", b3.busy, 1);
        end
      end
      if (b3.done) begin
        if (q3d.size() == 0) chk("n3_unexpected_done", 1, 0);
        else begin
          de = q3d.pop_front();
          chk("n3_err_count", b3.err_count, de.err);
          chk("n3_pass", b3.pass, de.pass);
          chk("n3_busy_fin", b3.busy, 0);
          chk("n3_valid_fin", b3.valid, 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b2.start = 1'b0; b2.tt = '0; b2.mode = '0;
    b3.start = 1'b0; b3.tt = '0; b3.mode = '0;
    reset = 1'b1;
    repeat (2) tick();

    chk("rst_busy", b2.busy, 0);
    chk("rst_valid", b2.valid, 0);
    chk("rst_done", b2.done, 0);
    chk("rst_pass", b2.pass, 0);
    chk("rst_m_idx", b2.m_idx, 0);
    chk("rst_err", b2.err_count, 0);
    chk("rst_s_nand", b2.s_nand, 0);
    chk("rst_s_ref", b2.s_ref, 0);
    chk("rst_mismatch", b2.mismatch, 0);
    chk("rst_n3_busy", b3.busy, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    // 1: single minterm, NOR reference -> clean pass
    sweep(1'b0, 8'h01, 3'd3, 0, 1'b1, "t1_nor");
    chk("t1_idle_after_fin", b2.busy, 0);
    // 2: same table against AND -> mismatches at m=0 and m=3
    sweep(1'b0, 8'h01, 3'd0, 2, 1'b0, "t2_and");

    // 3: start held high, tt changed mid-sweep; second sweep latches 4'hF
    push(1'b0, 8'h07, 3'd2, 0, 3);
    pushd(1'b0, 0, 1'b1);
    push(1'b0, 8'h0F, 3'd2, 0, 3);
    pushd(1'b0, 1, 1'b0);
    b2.start = 1'b1; b2.tt = 4'b0111; b2.mode = 3'd2;
    tick();
    tick();
    b2.tt = 4'hF;
    wait_done(1'b0, 3, "t3_first");
    tick();
    chk("t3_idle_busy", b2.busy, 0);
    chk("t3_idle_valid", b2.valid, 0);
    chk("t3_idle_pass_held", b2.pass, 1);
    tick();
    chk("t3_rearm_busy", b2.busy, 1);
    chk("t3_rearm_m", b2.m_idx, 0);
    b2.start = 1'b0;
    wait_done(1'b0, 4, "t3_second");
    tick();

    // 4: reset mid-sweep at m=2 -> immediate idle, no done
    push(1'b0, 8'h08, 3'd0, 0, 2);
    b2.start = 1'b1; b2.tt = 4'b1000; b2.mode = 3'd0;
    tick();
    b2.start = 1'b0;
    tick();
    tick();
    chk("t4_m_before_reset", b2.m_idx, 2);
    reset = 1'b1;
    tick();
    chk("t4_busy", b2.busy, 0);
    chk("t4_valid", b2.valid, 0);
    chk("t4_err", b2.err_count, 0);
    chk("t4_pass", b2.pass, 0);
    chk("t4_done", b2.done, 0);
    chk("t4_m_idx", b2.m_idx, 0);
    reset = 1'b0;
    repeat (6) tick();

    // 6: ZERO reference counts the ones of tt; TT reference always matches
    sweep(1'b0, 8'h06, 3'd7, 2, 1'b0, "t6_zero");
    sweep(1'b0, 8'h0B, 3'd6, 0, 1'b1, "t6_tt");

    // 5: three-input parity table against XOR then XNOR
    sweep(1'b1, 8'h96, 3'd4, 0, 1'b1, "t5_xor");
    sweep(1'b1, 8'h96, 3'd5, 8, 1'b0, "t5_xnor");

    repeat (3) tick();
    chk("q2v_left", q2v.size(), 0);
    chk("q2d_left", q2d.size(), 0);
    chk("q3v_left", q3v.size(), 0);
    chk("q3d_left", q3d.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
